// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file and its busy-bit scoreboard:
// depth derivation, index decode and the default hardwired-zero index.
package regfile_scoreboard_pkg;

   localparam int MAX_ADDR_BITS    = 10;
   localparam int MAX_DEPTH        = 1 << MAX_ADDR_BITS;
   localparam int ZERO_REG_DEFAULT = 31;

   function automatic int depth_of(input int addr_bits);
      return 1 << addr_bits;
   endfunction

   // Callers size-cast the result down to their own DEPTH.
   function automatic logic [MAX_DEPTH-1:0] onehot(input int unsigned idx);
      return MAX_DEPTH'(1) << idx;
   endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// Busy-bit scoreboard: claim/release arbitration, RAW busy lookups for two
// read ports and a sticky flag for releases of registers nobody owned.
module regfile_busy_table
   import regfile_scoreboard_pkg::*;
#(
   parameter int ADDR_BITS = 5,
   parameter int ZERO_REG  = ZERO_REG_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 wr_release,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic                 claim_en,
   input  logic [ADDR_BITS-1:0] claim_addr,
   input  logic [ADDR_BITS-1:0] rd_addr_a,
   input  logic [ADDR_BITS-1:0] rd_addr_b,
   output logic                 busy_a,
   output logic                 busy_b,
   output logic                 claim_ok,
   output logic                 release_err
);

   localparam int                 DEPTH    = depth_of(ADDR_BITS);
   localparam logic [ADDR_BITS-1:0] ZERO_IDX = ADDR_BITS'(ZERO_REG);

   logic [DEPTH-1:0] busy_reg;
   logic [DEPTH-1:0] busy_next;
   logic [DEPTH-1:0] wr_dec;
   logic [DEPTH-1:0] claim_dec;
   logic             release_fire;
   logic             release_err_reg;
   logic             release_err_next;

   assign wr_dec       = DEPTH'(onehot(int'(wr_addr)));
   assign claim_dec    = DEPTH'(onehot(int'(claim_addr)));
   assign release_fire = wr_en & wr_release;

   // A register being written back this cycle can be handed straight to a new owner.
   assign claim_ok = claim_en & ((claim_addr == ZERO_IDX) | ~busy_reg[claim_addr] |
                                 (release_fire & (wr_addr == claim_addr)));

   assign release_err_next = release_err_reg |
                             (release_fire & (wr_addr != ZERO_IDX) & ~busy_reg[wr_addr]);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
         if (gi == ZERO_REG) begin : g_zero
            assign busy_next[gi] = 1'b0;
         end else begin : g_bit
            // Claim wins over release so a same-cycle hand-over keeps the bit set.
            assign busy_next[gi] = (claim_ok & claim_dec[gi]) ? 1'b1 :
                                   (release_fire & wr_dec[gi]) ? 1'b0 : busy_reg[gi];
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_reg        <= '0;
         release_err_reg <= 1'b0;
      end else begin
         busy_reg        <= busy_next;
         release_err_reg <= release_err_next;
      end
   end

   assign busy_a      = busy_reg[rd_addr_a];
   assign busy_b      = busy_reg[rd_addr_b];
   assign release_err = release_err_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two combinational read ports, a
// hardwired-zero register, optional write-through bypass and a busy scoreboard.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 5,
   parameter int ZERO_REG  = ZERO_REG_DEFAULT,
   parameter int BYPASS    = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 wr_release,
   input  logic [ADDR_BITS-1:0] rd_addr_a,
   input  logic [ADDR_BITS-1:0] rd_addr_b,
   output logic [WIDTH-1:0]     rd_data_a,
   output logic [WIDTH-1:0]     rd_data_b,
   output logic                 busy_a,
   output logic                 busy_b,
   input  logic                 claim_en,
   input  logic [ADDR_BITS-1:0] claim_addr,
   output logic                 claim_ok,
   output logic                 release_err
);

   localparam int                 DEPTH    = depth_of(ADDR_BITS);
   localparam logic [ADDR_BITS-1:0] ZERO_IDX = ADDR_BITS'(ZERO_REG);
   localparam logic [DEPTH-1:0]     KEEP_MASK = ~DEPTH'(onehot(ZERO_REG));

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0] wr_we;

   assign wr_we = wr_en ? (DEPTH'(onehot(int'(wr_addr))) & KEEP_MASK) : '0;

   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            mem_reg[i] <= '0;
         end else if (wr_we[i]) begin
            mem_reg[i] <= wr_data;
         end
      end
   end

   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_BITS-1:0] addr);
      if (addr == ZERO_IDX) begin
         return '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
         return wr_data;
      end else begin
         return mem_reg[addr];
      end
   endfunction

   assign rd_data_a = read_port(rd_addr_a);
   assign rd_data_b = read_port(rd_addr_b);

   regfile_busy_table #(
      .ADDR_BITS (ADDR_BITS),
      .ZERO_REG  (ZERO_REG)
   ) u_busy_table (
      .clock       (clock),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_release  (wr_release),
      .wr_addr     (wr_addr),
      .claim_en    (claim_en),
      .claim_addr  (claim_addr),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .busy_a      (busy_a),
      .busy_b      (busy_b),
      .claim_ok    (claim_ok),
      .release_err (release_err)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (bypass and no-bypass builds).
module tb_regfile_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_release;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        busy_a;
   logic        busy_b;
   logic        claim_en;
   logic [4:0]  claim_addr;
   logic        claim_ok;
   logic        release_err;

   logic [31:0] nb_rd_data_a;
   logic [31:0] nb_rd_data_b;
   logic        nb_busy_a;
   logic        nb_busy_b;
   logic        nb_claim_ok;
   logic        nb_release_err;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(31), .BYPASS(1)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_release(wr_release), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .busy_a(busy_a), .busy_b(busy_b),
      .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
      .release_err(release_err)
   );

   regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(31), .BYPASS(0)) dut_nb (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_release(wr_release), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b), .busy_a(nb_busy_a),
      .busy_b(nb_busy_b), .claim_en(claim_en), .claim_addr(claim_addr),
      .claim_ok(nb_claim_ok), .release_err(nb_release_err)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_release = 0; claim_en = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle(); wr_addr = 0; wr_data = 0; claim_addr = 0;
      rd_addr_a = 0; rd_addr_b = 0;
      tick(); tick();
      reset = 0;
      for (int i = 0; i < 32; i++) begin
         rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
         #1;
         tests++;
         if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            fails++;
            $display("FAIL reset_data addr=%0d: got a=%h b=%h, expected 0", i, rd_data_a, rd_data_b);
         end
         tests++;
         if (busy_a !== 1'b0 || busy_b !== 1'b0 || release_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags addr=%0d: got busy_a=%b busy_b=%b err=%b, expected 0",
                     i, busy_a, busy_b, release_err);
         end
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_write_read();
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
      tick();
      idle(); rd_addr_a = 5; rd_addr_b = 5;
      #1;
      tests++;
      if (rd_data_a !== 32'hDEADBEEF || rd_data_b !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL write_r5: got a=%h b=%h, expected deadbeef", rd_data_a, rd_data_b);
      end
      wr_en = 1; wr_addr = 31; wr_data = 32'h12345678;
      tick();
      idle(); rd_addr_a = 31; rd_addr_b = 31;
      #1;
      tests++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
         fails++;
         $display("FAIL write_r31: got a=%h b=%h, expected 0", rd_data_a, rd_data_b);
      end
      $display("[TB] test_write_read done");
   endtask

   task automatic test_bypass();
      rd_addr_a = 7; rd_addr_b = 5;
      wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
      #1;
      tests++;
      if (rd_data_a !== 32'hA5A5A5A5) begin
         fails++;
         $display("FAIL bypass_on: got %h, expected a5a5a5a5", rd_data_a);
      end
      tests++;
      if (nb_rd_data_a !== 32'h0) begin
         fails++;
         $display("FAIL bypass_off: got %h, expected 0", nb_rd_data_a);
      end
      tests++;
      if (rd_data_b !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL bypass_other_port: got %h, expected deadbeef", rd_data_b);
      end
      tick();
      idle();
      #1;
      tests++;
      if (rd_data_a !== 32'hA5A5A5A5 || nb_rd_data_a !== 32'hA5A5A5A5) begin
         fails++;
         $display("FAIL bypass_stored: got %h/%h, expected a5a5a5a5", rd_data_a, nb_rd_data_a);
      end
      $display("[TB] test_bypass done");
   endtask

   task automatic test_claim();
      claim_en = 1; claim_addr = 3; rd_addr_a = 3;
      #1;
      tests++;
      if (claim_ok !== 1'b1 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL claim_first: got ok=%b busy=%b, expected ok=1 busy=0", claim_ok, busy_a);
      end
      tick();
      idle();
      #1;
      tests++;
      if (busy_a !== 1'b1) begin
         fails++;
         $display("FAIL claim_busy: got %b, expected 1", busy_a);
      end
      claim_en = 1; claim_addr = 3;
      #1;
      tests++;
      if (claim_ok !== 1'b0) begin
         fails++;
         $display("FAIL claim_reject: got %b, expected 0", claim_ok);
      end
      tick();
      idle();
      #1;
      tests++;
      if (busy_a !== 1'b1) begin
         fails++;
         $display("FAIL claim_still_busy: got %b, expected 1", busy_a);
      end
      wr_en = 1; wr_release = 1; wr_addr = 3; wr_data = 32'h55;
      tick();
      idle();
      #1;
      tests++;
      if (busy_a !== 1'b0 || rd_data_a !== 32'h55 || release_err !== 1'b0) begin
         fails++;
         $display("FAIL release_r3: got busy=%b data=%h err=%b, expected 0/55/0",
                  busy_a, rd_data_a, release_err);
      end
      $display("[TB] test_claim done");
   endtask

   task automatic test_handover();
      claim_en = 1; claim_addr = 9;
      tick();
      idle();
      wr_en = 1; wr_release = 1; wr_addr = 9; wr_data = 32'h77;
      claim_en = 1; claim_addr = 9;
      #1;
      tests++;
      if (claim_ok !== 1'b1) begin
         fails++;
         $display("FAIL handover_ok: got %b, expected 1", claim_ok);
      end
      tick();
      idle(); rd_addr_a = 9;
      #1;
      tests++;
      if (busy_a !== 1'b1 || rd_data_a !== 32'h77 || release_err !== 1'b0) begin
         fails++;
         $display("FAIL handover_state: got busy=%b data=%h err=%b, expected 1/77/0",
                  busy_a, rd_data_a, release_err);
      end
      wr_en = 1; wr_release = 1; wr_addr = 2; wr_data = 32'h22;
      tick();
      idle(); rd_addr_b = 2;
      #1;
      tests++;
      if (release_err !== 1'b1 || rd_data_b !== 32'h22) begin
         fails++;
         $display("FAIL release_nonbusy: got err=%b data=%h, expected 1/22", release_err, rd_data_b);
      end
      tick(); tick();
      tests++;
      if (release_err !== 1'b1) begin
         fails++;
         $display("FAIL release_err_sticky: got %b, expected 1", release_err);
      end
      $display("[TB] test_handover done");
   endtask

   task automatic test_reset_midflight();
      claim_en = 1; claim_addr = 4;
      wr_en = 1; wr_addr = 4; wr_data = 32'h11;
      tick();
      idle();
      reset = 1;
      claim_en = 1; claim_addr = 6; wr_en = 1; wr_addr = 6; wr_data = 32'h66;
      tick();
      reset = 0; idle();
      rd_addr_a = 4; rd_addr_b = 6;
      #1;
      tests++;
      if (busy_a !== 1'b0 || rd_data_a !== 32'h0 || release_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_r4: got busy=%b data=%h err=%b, expected 0/0/0",
                  busy_a, rd_data_a, release_err);
      end
      tests++;
      if (busy_b !== 1'b0 || rd_data_b !== 32'h0) begin
         fails++;
         $display("FAIL reset_discard_r6: got busy=%b data=%h, expected 0/0", busy_b, rd_data_b);
      end
      // Zero register: claims accepted without effect, releases never flag.
      wr_en = 1; wr_release = 1; wr_addr = 31; wr_data = 32'hFFFF;
      claim_en = 1; claim_addr = 31; rd_addr_b = 31;
      #1;
      tests++;
      if (claim_ok !== 1'b1) begin
         fails++;
         $display("FAIL claim_zero_ok: got %b, expected 1", claim_ok);
      end
      tick();
      idle();
      wr_release = 1; wr_addr = 4;
      tick();
      idle();
      #1;
      tests++;
      if (busy_b !== 1'b0 || release_err !== 1'b0 || rd_data_b !== 32'h0) begin
         fails++;
         $display("FAIL zero_and_ignored_release: got busy=%b err=%b data=%h, expected 0/0/0",
                  busy_b, release_err, rd_data_b);
      end
      $display("[TB] test_reset_midflight done");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_claim();
      test_handover();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
